systolic_ctrl: RTL and testbench

//   Sequencer for the 4x4 weight-stationary systolic array: buffers a weight matrix W and an

---
 rtl/systolic_ctrl.sv | 237 +++++++++++++++++++++++
 tb/tb_systolic_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_ctrl.sv
// -----------------------------------------------------------------------------
// systolic_ctrl
//   Sequencer for an N x N weight-stationary systolic array. The host fills a
//   weight buffer W and an activation buffer A; each accepted start pulse runs
//   one C = A x W job:
//     LOAD_W  (N cycles)           W rows shifted down the array columns,
//                                  last row first
//     SWITCH  (1 cycle)            arr_switch moves shadow weights to active
//     STREAM  (2N-1+OUT_LAT cyc)   skewed A rows fed in, column outputs
//                                  deskewed into the C buffer
//     DONE    (1 cycle)            done pulse, C valid
//
// Optional feature (macro SYSTOLIC_CTRL_RELOAD_SKIP_EN):
//   tracks whether W changed since the last weight load (w_dirty). A job
//   started with clean weights goes IDLE -> STREAM directly, skipping
//   LOAD_W and SWITCH.
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   wr_en/wr_sel      host write strobe; 0 = W buffer, 1 = A buffer
//   wr_row/wr_data    row index and row data (word j at [j*DW +: DW])
//   wr_err            one-cycle pulse after a write attempted while busy
//   start             job request, only honoured in IDLE
//   busy, done        job in progress; one-cycle completion pulse
//   rd_en/rd_row      result read request
//   rd_valid/rd_data  registered result row, one cycle after rd_en
//   arr_a, arr_b      row activation inputs / column weight inputs of array
//   arr_switch        weight switch strobe to array
//   arr_out           column outputs from array
// -----------------------------------------------------------------------------
module systolic_ctrl #(
  parameter int N       = 4,
  parameter int DW      = 32,
  parameter int OUT_LAT = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wr_en,
  input  logic            wr_sel,
  input  logic [1:0]      wr_row,
  input  logic [N*DW-1:0] wr_data,
  output logic            wr_err,
  input  logic            start,
  output logic            busy,
  output logic            done,
  input  logic            rd_en,
  input  logic [1:0]      rd_row,
  output logic            rd_valid,
  output logic [N*DW-1:0] rd_data,
  output logic [N*DW-1:0] arr_a,
  output logic [N*DW-1:0] arr_b,
  output logic            arr_switch,
  input  logic [N*DW-1:0] arr_out
);

  localparam int STREAM_LEN = 2*N - 1 + OUT_LAT;
  localparam int CW         = $clog2(STREAM_LEN);
  localparam logic [CW-1:0] LOAD_LAST   = CW'(N - 1);
  localparam logic [CW-1:0] STREAM_LAST = CW'(STREAM_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_W,
    S_SWITCH,
    S_STREAM,
    S_DONE
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [DW-1:0]   w_buf_q [N][N];
  logic [DW-1:0]   w_buf_d [N][N];
  logic [DW-1:0]   a_buf_q [N][N];
  logic [DW-1:0]   a_buf_d [N][N];
  logic [DW-1:0]   c_buf_q [N][N];
  logic [DW-1:0]   c_buf_d [N][N];

  logic            wr_err_q, wr_err_d;
  logic            rd_valid_q, rd_valid_d;
  logic [N*DW-1:0] rd_data_q, rd_data_d;

  logic            idle;
  logic            w_write;
  logic            a_write;
  logic            need_load;

  // Host writes land only while idle; a write in the start cycle still
  // completes, so the job sees the new data.
  assign idle    = (state_q == S_IDLE);
  assign w_write = wr_en & ~wr_sel & idle;
  assign a_write = wr_en &  wr_sel & idle;

`ifdef SYSTOLIC_CTRL_RELOAD_SKIP_EN
  logic w_dirty_q, w_dirty_d;

  always_comb begin
    w_dirty_d = w_dirty_q;
    if (state_q == S_SWITCH) w_dirty_d = 1'b0;
    if (w_write)             w_dirty_d = 1'b1;
  end

  // Reset leaves the array contents unknown to us, so force a reload.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) w_dirty_q <= 1'b1;
    else     w_dirty_q <= w_dirty_d;
  end

  // A W write in the same cycle as start must also force the reload.
  assign need_load = w_dirty_q | w_write;
`else
  assign need_load = 1'b1;
`endif

  // Next-state logic and state-decoded control outputs
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy       = 1'b1;
    done       = 1'b0;
    arr_switch = 1'b0;
    case (state_q)
      S_IDLE: begin
        busy  = 1'b0;
        cnt_d = '0;
        if (start) state_d = need_load ? S_LOAD_W : S_STREAM;
      end
      S_LOAD_W: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LOAD_LAST) begin
          state_d = S_SWITCH;
          cnt_d   = '0;
        end
      end
      S_SWITCH: begin
        arr_switch = 1'b1;
        cnt_d      = '0;
        state_d    = S_STREAM;
      end
      S_STREAM: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == STREAM_LAST) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        busy    = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Array drive: weights go last row first so row i ends up holding W[i];
  // activations are skewed so row i lags row i-1 by one cycle.
  always_comb begin
    arr_a = '0;
    arr_b = '0;
    if (state_q == S_LOAD_W) begin
      for (int r = 0; r < N; r++)
        if (int'(cnt_q) == N - 1 - r)
          for (int j = 0; j < N; j++) arr_b[j*DW +: DW] = w_buf_q[r][j];
    end
    if (state_q == S_STREAM) begin
      for (int i = 0; i < N; i++)
        for (int r = 0; r < N; r++)
          if (int'(cnt_q) == r + i) arr_a[i*DW +: DW] = a_buf_q[r][i];
    end
  end

  // Buffer updates: host writes and deskewed result capture.
  // Column j of result row r emerges OUT_LAT cycles after A[r][0] entered,
  // plus the j-cycle skew across the array.
  always_comb begin
    w_buf_d = w_buf_q;
    a_buf_d = a_buf_q;
    c_buf_d = c_buf_q;
    for (int r = 0; r < N; r++) begin
      if (int'(wr_row) == r) begin
        for (int j = 0; j < N; j++) begin
          if (w_write) w_buf_d[r][j] = wr_data[j*DW +: DW];
          if (a_write) a_buf_d[r][j] = wr_data[j*DW +: DW];
        end
      end
    end
    if (state_q == S_STREAM) begin
      for (int r = 0; r < N; r++)
        for (int j = 0; j < N; j++)
          if (int'(cnt_q) == r + j + OUT_LAT) c_buf_d[r][j] = arr_out[j*DW +: DW];
    end
  end

  // Host-side status and read port
  always_comb begin
    wr_err_d   = wr_en & ~idle;
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) begin
      for (int r = 0; r < N; r++)
        if (int'(rd_row) == r)
          for (int j = 0; j < N; j++) rd_data_d[j*DW +: DW] = c_buf_q[r][j];
    end
  end

  // Control registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      wr_err_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_err_q   <= wr_err_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
    end
  end

  // Buffers keep their contents across reset
  always_ff @(posedge clk) begin
    w_buf_q <= w_buf_d;
    a_buf_q <= a_buf_d;
    c_buf_q <= c_buf_d;
  end

  assign wr_err   = wr_err_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;

endmodule

// File: tb/tb_systolic_ctrl.sv
// -----------------------------------------------------------------------------
// tb_systolic_ctrl
//   Directed bench for systolic_ctrl. A behavioural weight-stationary 4x4
//   array (weights shift down columns, activations flow right, partial sums
//   flow down, OUT_LAT = 4) closes the loop around the controller.
// -----------------------------------------------------------------------------
module tb_systolic_ctrl;

  localparam int N       = 4;
  localparam int DW      = 32;
  localparam int OUT_LAT = 4;
  localparam int W       = N * DW;

`ifdef SYSTOLIC_CTRL_RELOAD_SKIP_EN
  localparam int LAT_CLEAN = 12;
`else
  localparam int LAT_CLEAN = 17;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_en = 1'b0;
  logic         wr_sel = 1'b0;
  logic [1:0]   wr_row = '0;
  logic [W-1:0] wr_data = '0;
  logic         wr_err;
  logic         start = 1'b0;
  logic         busy;
  logic         done;
  logic         rd_en = 1'b0;
  logic [1:0]   rd_row = '0;
  logic         rd_valid;
  logic [W-1:0] rd_data;
  logic [W-1:0] arr_a;
  logic [W-1:0] arr_b;
  logic         arr_switch;
  logic [W-1:0] arr_out;

  always #5 clk = ~clk;

  systolic_ctrl #(.N(N), .DW(DW), .OUT_LAT(OUT_LAT)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_row(wr_row), .wr_data(wr_data),
    .wr_err(wr_err), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_row(rd_row), .rd_valid(rd_valid), .rd_data(rd_data),
    .arr_a(arr_a), .arr_b(arr_b), .arr_switch(arr_switch), .arr_out(arr_out)
  );

  // Behavioural systolic array
  logic [DW-1:0] m_wb [N][N];
  logic [DW-1:0] m_wt [N][N];
  logic [DW-1:0] m_ar [N][N];
  logic [DW-1:0] m_ps [N][N];

  function automatic logic [DW-1:0] a_in(input int i, input int j);
    if (j == 0) return arr_a[i*DW +: DW];
    else        return m_ar[i][j-1];
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        m_ar[i][j] <= a_in(i, j);
        if (i == 0) begin
          m_ps[i][j] <= a_in(i, j) * m_wt[i][j];
          m_wb[i][j] <= arr_b[j*DW +: DW];
        end else begin
          m_ps[i][j] <= m_ps[i-1][j] + a_in(i, j) * m_wt[i][j];
          m_wb[i][j] <= m_wb[i-1][j];
        end
        if (arr_switch) m_wt[i][j] <= m_wb[i][j];
      end
    end
  end

  always_comb begin
    arr_out = '0;
    for (int j = 0; j < N; j++) arr_out[j*DW +: DW] = m_ps[N-1][j];
  end

  // Bench state
  int vectors    = 0;
  int miscompares = 0;
  logic [DW-1:0] wm [N][N];
  logic [DW-1:0] am [N][N];
  logic [DW-1:0] ec [N][N];
  int lat, sw, ndone;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic write_row(input logic sel, input int row, input logic [W-1:0] d);
    wr_en   = 1'b1;
    wr_sel  = sel;
    wr_row  = row[1:0];
    wr_data = d;
    @(posedge clk); #1;
    wr_en   = 1'b0;
  endtask

  function automatic logic [W-1:0] row_w(input int r);
    logic [W-1:0] d = '0;
    for (int j = 0; j < N; j++) d[j*DW +: DW] = wm[r][j];
    return d;
  endfunction

  function automatic logic [W-1:0] row_a(input int r);
    logic [W-1:0] d = '0;
    for (int j = 0; j < N; j++) d[j*DW +: DW] = am[r][j];
    return d;
  endfunction

  task automatic write_w();
    for (int r = 0; r < N; r++) write_row(1'b0, r, row_w(r));
  endtask

  task automatic write_a();
    for (int r = 0; r < N; r++) write_row(1'b1, r, row_a(r));
  endtask

  task automatic golden();
    logic [DW-1:0] acc;
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        acc = '0;
        for (int i = 0; i < N; i++) acc = acc + am[r][i] * wm[i][j];
        ec[r][j] = acc;
      end
  endtask

  // Pulses start (any pending write strobe shares the first edge) and waits
  // for done, bounded. Returns cycles to done and arr_switch-high cycles.
  task automatic run_job(output int l, output int s);
    l = 0;
    s = 0;
    start = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      wr_en = 1'b0;
      l++;
      if (arr_switch) s++;
      if (done) break;
    end
  endtask

  task automatic check_c(input string tag);
    logic [W-1:0] e;
    for (int r = 0; r < N; r++) begin
      e = '0;
      for (int j = 0; j < N; j++) e[j*DW +: DW] = ec[r][j];
      rd_en  = 1'b1;
      rd_row = r[1:0];
      @(posedge clk); #1;
      chk($sformatf("%s_vld%0d", tag, r), W'(rd_valid), W'(1));
      chk($sformatf("%s_row%0d", tag, r), rd_data, e);
    end
    rd_en = 1'b0;
    @(posedge clk); #1;
    chk($sformatf("%s_vld_off", tag), W'(rd_valid), W'(0));
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",   W'(busy),       W'(0));
    chk("rst_done",   W'(done),       W'(0));
    chk("rst_wr_err", W'(wr_err),     W'(0));
    chk("rst_rd_vld", W'(rd_valid),   W'(0));
    chk("rst_switch", W'(arr_switch), W'(0));
    chk("rst_arr_a",  arr_a,          W'(0));
    chk("rst_arr_b",  arr_b,          W'(0));
    chk("rst_rd_data", rd_data,       W'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // 1: identity weights, C must equal A
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        wm[r][j] = (r == j) ? 32'd1 : 32'd0;
        am[r][j] = 32'(r*4 + j + 1);
        ec[r][j] = 32'(r*4 + j + 1);
      end
    write_w();
    write_a();
    run_job(lat, sw);
    chk("ident_lat", W'(lat), W'(17));
    chk("ident_sw",  W'(sw),  W'(1));
    @(posedge clk); #1;
    chk("ident_done_pulse", W'(done), W'(0));
    chk("ident_busy_off",   W'(busy), W'(0));
    check_c("ident");

    // 2: full matrix W[i][j]=i+j; C[0][0] = 0*1+1*2+2*3+3*4 = 20
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        wm[r][j] = 32'(r + j);
        am[r][j] = 32'(r*4 + j + 1);
      end
    write_w();
    golden();
    chk("full_c00_model", W'(ec[0][0]), W'(20));
    run_job(lat, sw);
    chk("full_lat", W'(lat), W'(17));
    chk("full_sw",  W'(sw),  W'(1));
    check_c("full");

    // 4: write and start while busy are dropped
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_hi", W'(busy), W'(1));
    wr_en   = 1'b1;
    wr_sel  = 1'b0;
    wr_row  = 2'd0;
    wr_data = {N{32'd9}};
    start   = 1'b1;
    @(posedge clk); #1;
    wr_en = 1'b0;
    start = 1'b0;
    chk("busy_wr_err", W'(wr_err), W'(1));
    @(posedge clk); #1;
    chk("busy_wr_err_off", W'(wr_err), W'(0));
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("busy_one_done", W'(ndone), W'(1));
    check_c("busy");

    // 3: modulo wrap, (-1)*2*4 = -8
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        wm[r][j] = 32'd2;
        am[r][j] = 32'hFFFF_FFFF;
        ec[r][j] = 32'hFFFF_FFF8;
      end
    write_w();
    write_a();
    run_job(lat, sw);
    chk("wrap_lat", W'(lat), W'(17));
    check_c("wrap");

    // 5: reset during STREAM cycle 3, then a clean job
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        wm[r][j] = 32'(r*4 + j + 1);
        am[r][j] = 32'((r + 1) * (j + 2));
      end
    write_w();
    write_a();
    golden();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("mrst_busy",   W'(busy),       W'(0));
    chk("mrst_done",   W'(done),       W'(0));
    chk("mrst_switch", W'(arr_switch), W'(0));
    chk("mrst_arr_a",  arr_a,          W'(0));
    chk("mrst_arr_b",  arr_b,          W'(0));
    @(posedge clk); #1;
    rst = 1'b0;
    ndone = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    chk("mrst_no_done", W'(ndone), W'(0));
    run_job(lat, sw);
    chk("mrst_lat", W'(lat), W'(17));
    check_c("mrst");

    // 6: back-to-back jobs, second only rewrites A (last row with start)
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) begin
        wm[r][j] = 32'(j - r + 7);
        am[r][j] = 32'(r + 3*j);
      end
    write_w();
    write_a();
    golden();
    run_job(lat, sw);
    chk("skip_lat1", W'(lat), W'(17));
    check_c("skip1");
    for (int r = 0; r < N; r++)
      for (int j = 0; j < N; j++) am[r][j] = 32'(100 + r*10 + j);
    for (int r = 0; r < N - 1; r++) write_row(1'b1, r, row_a(r));
    wr_en   = 1'b1;
    wr_sel  = 1'b1;
    wr_row  = 2'd3;
    wr_data = row_a(3);
    golden();
    run_job(lat, sw);
    chk("skip_lat2", W'(lat), W'(LAT_CLEAN));
    chk("skip_sw2",  W'(sw),  W'(LAT_CLEAN == 17 ? 1 : 0));
    check_c("skip2");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
